// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: 8N1 UART serializer draining a normal-mode FIFO, with CTS flow control and frame counter.
// Define UART_FIFO_TX_PARITY_EN for an 8E1 frame with an even-parity bit after D7.
module uart_fifo_tx #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        fifo_empty_i,
    input  logic [7:0]  fifo_q_i,
    output logic        fifo_rdreq_o,
    input  logic        cts_n_i,
    output logic        txd_o,
    output logic        busy_o,
    output logic [15:0] tx_count_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_FIFO_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [15:0] DIV = 16'(BAUD_DIV);

    logic [1:0]  rst_sync_q;
    logic        rst_n;
    logic [1:0]  cts_sync_q;
    logic        empty_q;
    logic [15:0] cnt_q, cnt_d;
    logic        tick;
    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic        txd_q, txd_d;
    logic        rdreq_q, rdreq_d;
    logic        rd_dly_q;
    logic        busy_q, busy_d;
    logic [15:0] tx_count_q, tx_count_d;
`ifdef UART_FIFO_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    // Asynchronous assertion, synchronized release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign tick  = (cnt_q == DIV);
    assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        txd_d      = txd_q;
        rdreq_d    = 1'b0;
        busy_d     = busy_q;
        tx_count_d = tx_count_q;
`ifdef UART_FIFO_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            S_IDLE: if (tick && !empty_q && !cts_sync_q[1]) begin
                rdreq_d = 1'b1;
                busy_d  = 1'b1;
                state_d = S_LOAD;
            end
            // FIFO data is valid one cycle after the strobe was sampled.
            S_LOAD: begin
                if (rd_dly_q) begin
                    shift_d = fifo_q_i;
`ifdef UART_FIFO_TX_PARITY_EN
                    par_d   = ^fifo_q_i;
`endif
                end
                if (tick) begin
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: if (tick) begin
                txd_d   = shift_q[0];
                shift_d = shift_q >> 1;
                idx_d   = 3'd0;
                state_d = S_DATA;
            end
            S_DATA: if (tick) begin
                if (idx_q == 3'd7) begin
`ifdef UART_FIFO_TX_PARITY_EN
                    txd_d   = par_q;
                    state_d = S_PARITY;
`else
                    txd_d   = 1'b1;
                    state_d = S_STOP;
`endif
                end else begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                end
            end
`ifdef UART_FIFO_TX_PARITY_EN
            S_PARITY: if (tick) begin
                txd_d   = 1'b1;
                state_d = S_STOP;
            end
`endif
            S_STOP: if (tick) begin
                tx_count_d = tx_count_q + 16'd1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cts_sync_q <= 2'b11;
            empty_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            txd_q      <= 1'b1;
            rdreq_q    <= 1'b0;
            rd_dly_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_count_q <= '0;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n_i};
            empty_q    <= fifo_empty_i;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            txd_q      <= txd_d;
            rdreq_q    <= rdreq_d;
            rd_dly_q   <= rdreq_q;
            busy_q     <= busy_d;
            tx_count_q <= tx_count_d;
        end
    end

`ifdef UART_FIFO_TX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign fifo_rdreq_o = rdreq_q;
    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign tx_count_o   = tx_count_q;
endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

Byte-wide 8N1 UART serializer that drains the read side of the dual-clock debug FIFO on the board-side clock and drives the host UART TXD pin. It sits directly downstream of the capture FIFO that collects ASCII-encoded MII nibbles. It replaces the inline transmit state machine in the top level with a reusable block. It adds hardware flow control and a transmitted-byte counter for the HEX displays.

## Interface
- BAUD_DIV, 434: bit period = BAUD_DIV+1 clocks (50 MHz / 435 ≈ 115200 baud); legal range 4..65535.
- clk_i  input  1  board clock (clk_50); all logic on rising edge.
- reset_n_i  input  1  reset, asynchronous and active-low. Assertion is asynchronous; deassertion is synchronized internally with a 2-FF stage.
- fifo_empty_i  input  1  FIFO read-side empty (rdempty).
- fifo_q_i  input  8  FIFO read data. Normal (non-show-ahead) mode: valid the cycle after rdreq is sampled.
- fifo_rdreq_o  output  1  single-cycle FIFO read strobe.
- cts_n_i  input  1  host clear-to-send, active-low, asynchronous; 2-FF synchronized inside.
- txd_o  output  1  serial data, idle high.
- busy_o  output  1  high from the read strobe until the end of the stop bit.
- tx_count_o  output  16  count of completed frames; wraps 0xFFFF→0x0000.

## Operation
- Bit tick:
  - Free-running 16-bit counter counts 0..BAUD_DIV.
  - At BAUD_DIV it clears and `tick` pulses for 1 clock.
  - The counter runs in every state.
- States:
  - **IDLE**: at tick, if !fifo_empty_i and synchronized cts_n low → fifo_rdreq_o=1 for exactly one clock, go to LOAD. Otherwise stay.
  - **LOAD**: capture fifo_q_i into the 8-bit shift register on the second clock edge after the edge that raised fifo_rdreq_o. At the next tick → txd_o=0, go to START.
  - **START**: at tick → txd_o=shift[0], shift right, bit index=0, go to DATA.
  - **DATA**: at each tick, drive the next bit LSB-first. After bit 7 has been held one period, go to PARITY (if enabled) or STOP and drive the corresponding level.
  - **STOP**: txd_o=1 held one bit period. At tick → tx_count_o++, busy_o=0, go to IDLE.
- txd_o changes only on tick edges (registered); no glitches.
- cts_n is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- fifo_rdreq_o is never asserted while fifo_empty_i=1 or outside IDLE, so no FIFO underflow is possible.
- Back-to-back bytes:
  - The read strobe is issued at the tick ending STOP+1 period, giving ≥2 stop-bit periods between frames.
  - Min frame spacing = 12 bit periods (13 with parity).

## Timing
- Reset values: txd_o=1, fifo_rdreq_o=0, busy_o=0, tx_count_o=0. State=IDLE, tick counter=0, shift register=0.
- Latency: fifo_empty_i falling → read strobe ≤ BAUD_DIV+1 clocks. Read strobe tick → start-bit edge = 1 bit period.
- Start bit, data bits and stop bit are each exactly BAUD_DIV+1 clocks.
- busy_o rises on the same edge as fifo_rdreq_o and falls on the same edge as the tx_count_o increment.
- Reset mid-frame: outputs go to reset values immediately (async). The in-flight byte is lost; the FIFO entry is already consumed.
- Simultaneous tick and fifo_empty_i falling on the same cycle: the registered empty is not seen; the read waits for the next tick.
- The BAUD_DIV≥4 constraint guarantees the LOAD capture completes before the next tick.

## Configuration
- UART_FIFO_TX_PARITY_EN defined:
  - PARITY state inserted after D7; txd_o = even parity (XOR of the 8 data bits) for one bit period.
  - Frame is 8E1.
- Not defined: no PARITY state, frame is 8N1, parity logic absent.

## Test plan
- Reset, FIFO holding 0x41, cts_n=0, BAUD_DIV=4:
  - Expect one rdreq pulse.
  - txd sequence 0,1,0,0,0,0,0,1,0,1, each 5 clocks.
  - tx_count_o=1, busy_o low after stop.
- FIFO with 0x30,0x31,0x0A back-to-back:
  - Expect exactly 3 rdreq pulses and 3 correct frames.
  - ≥2 idle-high periods between frames; tx_count_o=3.
- cts_n=1 with non-empty FIFO for 100 ticks:
  - No rdreq, txd stays 1.
  - Then cts_n=0 → frame begins within 2 ticks + 2 clocks.
- Deassert reset_n_i during DATA bit 3:
  - txd=1 immediately, busy_o=0, tx_count_o=0.
  - After release with FIFO empty, no activity.
- Preload tx_count_o to 0xFFFF (force), send one byte → 0x0000.
- With UART_FIFO_TX_PARITY_EN: send 0x07 → parity bit 1; send 0x03 → parity bit 0. Frames are 11 bit periods long.
